// File: rtl/mem_stage.sv
// Memory stage of the in-order pipeline: issues one data-bus access per load/store,
// aligns load data and store lanes, and flags misaligned or undefined accesses.
package mem_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst32;
    logic        instValid;
    logic [31:0] aux;
    logic [4:0]  destReg;
    logic [31:0] res;
    logic [31:0] storeData;
  } ex2memPkt;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst32;
    logic        instValid;
    logic [4:0]  destReg;
    logic [31:0] wbData;
    logic        misaligned;
  } mem2wbPkt;
endpackage

module mem_stage
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  ex2memPkt    ex2mem_i,
  input  logic        stall_i,
  output logic        stall_o,
  output mem2wbPkt    mem2wb_o,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state, state_next;
  ex2memPkt    mem_reg;
  logic [31:0] rdata_q;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  offset;
  logic        is_load, is_store, is_mem, mis, mem_ok;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic        unused_aux;

  assign unused_aux = ^mem_reg.aux;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mem_reg <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_next;
      if (!stall_o && !stall_i)
        mem_reg <= ex2mem_i;
      if (state == REQ && dmem_ack && is_load)
        rdata_q <= dmem_rdata;
    end
  end

  // Undefined funct3 encodings are reported through the misaligned flag.
  always_comb begin
    opcode   = mem_reg.inst32[6:0];
    funct3   = mem_reg.inst32[14:12];
    offset   = mem_reg.res[1:0];
    is_load  = mem_reg.instValid && (opcode == 7'b0000011);
    is_store = mem_reg.instValid && (opcode == 7'b0100011);
    mis      = 1'b0;
    if (is_load) begin
      case (funct3)
        3'b000, 3'b100: mis = 1'b0;
        3'b001, 3'b101: mis = offset[0];
        3'b010:         mis = (offset != 2'b00);
        default:        mis = 1'b1;
      endcase
    end else if (is_store) begin
      case (funct3)
        3'b000:  mis = 1'b0;
        3'b001:  mis = offset[0];
        3'b010:  mis = (offset != 2'b00);
        default: mis = 1'b1;
      endcase
    end
    is_mem = is_load || is_store;
    mem_ok = is_mem && !mis;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mem_ok) state_next = REQ;
      REQ:     if (dmem_ack) state_next = DONE;
      DONE:    if (!stall_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign stall_o   = (state == REQ) || (state == IDLE && mem_ok);
  assign dmem_req  = (state == REQ);
  assign dmem_we   = is_store;
  assign dmem_addr = {mem_reg.res[31:2], 2'b00};

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = '0;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          dmem_be    = 4'b0001 << offset;
          dmem_wdata = {4{mem_reg.storeData[7:0]}};
        end
        2'b01: begin
          dmem_be    = offset[1] ? 4'b1100 : 4'b0011;
          dmem_wdata = {2{mem_reg.storeData[15:0]}};
        end
        default: dmem_wdata = mem_reg.storeData;
      endcase
    end
  end

  always_comb begin
    ld_byte = rdata_q[{offset, 3'b000} +: 8];
    ld_half = offset[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (funct3)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'd0, ld_byte};
      3'b101:  load_data = {16'd0, ld_half};
      default: load_data = rdata_q;
    endcase
  end

  // A valid memory op shows as a bubble until its access has completed.
  always_comb begin
    mem2wb_o            = '0;
    mem2wb_o.pc         = mem_reg.pc;
    mem2wb_o.inst32     = mem_reg.inst32;
    if (!is_mem) begin
      mem2wb_o.instValid = mem_reg.instValid;
      mem2wb_o.destReg   = mem_reg.destReg;
      mem2wb_o.wbData    = mem_reg.res;
    end else if (mis) begin
      mem2wb_o.instValid  = 1'b1;
      mem2wb_o.misaligned = 1'b1;
      mem2wb_o.wbData     = mem_reg.res;
    end else if (state == DONE) begin
      mem2wb_o.instValid = 1'b1;
      mem2wb_o.destReg   = is_store ? 5'd0 : mem_reg.destReg;
      mem2wb_o.wbData    = is_store ? 32'd0 : load_data;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: pass-through ops, loads, stores,
// misalignment, downstream stall in DONE and reset during an access.
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk;
  logic        rst;
  ex2memPkt    ex2mem_i;
  logic        stall_i;
  logic        stall_o;
  mem2wbPkt    mem2wb_o;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .clk        (clk),
    .rst        (rst),
    .ex2mem_i   (ex2mem_i),
    .stall_i    (stall_i),
    .stall_o    (stall_o),
    .mem2wb_o   (mem2wb_o),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic ex2memPkt mk_pkt(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [31:0] res, input logic [31:0] sd,
                                      input logic [4:0] rd);
    ex2memPkt p;
    p           = '0;
    p.pc        = 32'h0000_0100;
    p.inst32    = {17'd0, f3, 5'd0, op};
    p.instValid = 1'b1;
    p.destReg   = rd;
    p.res       = res;
    p.storeData = sd;
    return p;
  endfunction

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  task automatic test_reset();
    rst = 1'b1; ex2mem_i = '0; stall_i = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %0h expected 0", dmem_req); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %0h expected 0", stall_o); end
    checks++; if (mem2wb_o.instValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0h expected 0", mem2wb_o.instValid); end
    checks++; if (mem2wb_o.destReg !== 5'd0) begin errors++; $display("[TB] FAIL reset_dest: got %0h expected 0", mem2wb_o.destReg); end
  endtask

  task automatic test_add();
    @(negedge clk);
    ex2mem_i = mk_pkt(OP_ALU, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
    @(negedge clk); #1;
    ex2mem_i = '0;
    checks++; if (mem2wb_o.wbData !== 32'h0000_1234) begin errors++; $display("[TB] FAIL add_wb: got %h expected 00001234", mem2wb_o.wbData); end
    checks++; if (mem2wb_o.destReg !== 5'd5) begin errors++; $display("[TB] FAIL add_dest: got %0d expected 5", mem2wb_o.destReg); end
    checks++; if (mem2wb_o.instValid !== 1'b1) begin errors++; $display("[TB] FAIL add_valid: got %0h expected 1", mem2wb_o.instValid); end
    checks++; if (mem2wb_o.pc !== 32'h0000_0100) begin errors++; $display("[TB] FAIL add_pc: got %h expected 00000100", mem2wb_o.pc); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL add_stall: got %0h expected 0", stall_o); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL add_req: got %0h expected 0", dmem_req); end
  endtask

  task automatic test_lb();
    @(negedge clk);
    ex2mem_i = mk_pkt(OP_LOAD, 3'b000, 32'h0000_1003, 32'h0, 5'd7);
    @(negedge clk); #1;
    ex2mem_i = '0;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("[TB] FAIL lb_idle_stall: got %0h expected 1", stall_o); end
    checks++; if (mem2wb_o.instValid !== 1'b0) begin errors++; $display("[TB] FAIL lb_idle_bubble: got %0h expected 0", mem2wb_o.instValid); end
    checks++; if (mem2wb_o.destReg !== 5'd0) begin errors++; $display("[TB] FAIL lb_idle_dest: got %0d expected 0", mem2wb_o.destReg); end
    @(negedge clk); #1;
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL lb_req: got %0h expected 1", dmem_req); end
    checks++; if (dmem_addr !== 32'h0000_1000) begin errors++; $display("[TB] FAIL lb_addr: got %h expected 00001000", dmem_addr); end
    checks++; if (dmem_we !== 1'b0) begin errors++; $display("[TB] FAIL lb_we: got %0h expected 0", dmem_we); end
    checks++; if (stall_o !== 1'b1) begin errors++; $display("[TB] FAIL lb_req_stall: got %0h expected 1", stall_o); end
    dmem_ack = 1'b1; dmem_rdata = 32'h80AA_BBCC;
    @(negedge clk);
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL lb_done_stall: got %0h expected 0", stall_o); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL lb_done_req: got %0h expected 0", dmem_req); end
    checks++; if (mem2wb_o.wbData !== 32'hFFFF_FF80) begin errors++; $display("[TB] FAIL lb_wb: got %h expected ffffff80", mem2wb_o.wbData); end
    checks++; if (mem2wb_o.destReg !== 5'd7) begin errors++; $display("[TB] FAIL lb_dest: got %0d expected 7", mem2wb_o.destReg); end
    checks++; if (mem2wb_o.instValid !== 1'b1) begin errors++; $display("[TB] FAIL lb_valid: got %0h expected 1", mem2wb_o.instValid); end
    @(negedge clk); #1;
    checks++; if (mem2wb_o.instValid !== 1'b0) begin errors++; $display("[TB] FAIL lb_after_valid: got %0h expected 0", mem2wb_o.instValid); end
  endtask

  task automatic test_sh();
    @(negedge clk);
    ex2mem_i = mk_pkt(OP_STORE, 3'b001, 32'h0000_2002, 32'h1234_5678, 5'd9);
    @(negedge clk); #1;
    ex2mem_i = '0;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL sh_idle_req: got %0h expected 0", dmem_req); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if (dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL sh_req%0d: got %0h expected 1", i, dmem_req); end
      checks++; if (dmem_be !== 4'b1100) begin errors++; $display("[TB] FAIL sh_be%0d: got %b expected 1100", i, dmem_be); end
      checks++; if (dmem_wdata !== 32'h5678_5678) begin errors++; $display("[TB] FAIL sh_wdata%0d: got %h expected 56785678", i, dmem_wdata); end
      checks++; if (dmem_we !== 1'b1) begin errors++; $display("[TB] FAIL sh_we%0d: got %0h expected 1", i, dmem_we); end
      checks++; if (dmem_addr !== 32'h0000_2000) begin errors++; $display("[TB] FAIL sh_addr%0d: got %h expected 00002000", i, dmem_addr); end
      if (i == 2) dmem_ack = 1'b1;
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL sh_done_req: got %0h expected 0", dmem_req); end
    checks++; if (mem2wb_o.destReg !== 5'd0) begin errors++; $display("[TB] FAIL sh_dest: got %0d expected 0", mem2wb_o.destReg); end
    checks++; if (mem2wb_o.wbData !== 32'd0) begin errors++; $display("[TB] FAIL sh_wb: got %h expected 0", mem2wb_o.wbData); end
    checks++; if (mem2wb_o.instValid !== 1'b1) begin errors++; $display("[TB] FAIL sh_valid: got %0h expected 1", mem2wb_o.instValid); end
    @(negedge clk);
  endtask

  task automatic test_sb();
    @(negedge clk);
    ex2mem_i = mk_pkt(OP_STORE, 3'b000, 32'h0000_5001, 32'h0000_00AB, 5'd2);
    @(negedge clk);
    ex2mem_i = '0;
    @(negedge clk); #1;
    checks++; if (dmem_be !== 4'b0010) begin errors++; $display("[TB] FAIL sb_be: got %b expected 0010", dmem_be); end
    checks++; if (dmem_wdata !== 32'hABAB_ABAB) begin errors++; $display("[TB] FAIL sb_wdata: got %h expected abababab", dmem_wdata); end
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    checks++; if (mem2wb_o.destReg !== 5'd0) begin errors++; $display("[TB] FAIL sb_dest: got %0d expected 0", mem2wb_o.destReg); end
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    ex2mem_i = mk_pkt(OP_LOAD, 3'b010, 32'h0000_3001, 32'h0, 5'd4);
    @(negedge clk); #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL mis_lw_req: got %0h expected 0", dmem_req); end
    checks++; if (mem2wb_o.misaligned !== 1'b1) begin errors++; $display("[TB] FAIL mis_lw_flag: got %0h expected 1", mem2wb_o.misaligned); end
    checks++; if (mem2wb_o.destReg !== 5'd0) begin errors++; $display("[TB] FAIL mis_lw_dest: got %0d expected 0", mem2wb_o.destReg); end
    checks++; if (mem2wb_o.instValid !== 1'b1) begin errors++; $display("[TB] FAIL mis_lw_valid: got %0h expected 1", mem2wb_o.instValid); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL mis_lw_stall: got %0h expected 0", stall_o); end
    ex2mem_i = mk_pkt(OP_STORE, 3'b011, 32'h0000_7000, 32'h1, 5'd6);
    @(negedge clk); #1;
    ex2mem_i = '0;
    checks++; if (mem2wb_o.misaligned !== 1'b1) begin errors++; $display("[TB] FAIL mis_undef_flag: got %0h expected 1", mem2wb_o.misaligned); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL mis_undef_stall: got %0h expected 0", stall_o); end
    @(negedge clk); #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL mis_noreq: got %0h expected 0", dmem_req); end
  endtask

  task automatic test_lhu_stall();
    @(negedge clk);
    ex2mem_i = mk_pkt(OP_LOAD, 3'b101, 32'h0000_4002, 32'h0, 5'd3);
    @(negedge clk);
    ex2mem_i = '0;
    @(negedge clk); #1;
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL lhu_req: got %0h expected 1", dmem_req); end
    dmem_ack = 1'b1; dmem_rdata = 32'hBEEF_0000; stall_i = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0; dmem_rdata = 32'h1357_9BDF;
    #1;
    checks++; if (mem2wb_o.wbData !== 32'h0000_BEEF) begin errors++; $display("[TB] FAIL lhu_wb0: got %h expected 0000beef", mem2wb_o.wbData); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL lhu_req0: got %0h expected 0", dmem_req); end
    @(negedge clk); #1;
    checks++; if (mem2wb_o.wbData !== 32'h0000_BEEF) begin errors++; $display("[TB] FAIL lhu_wb1: got %h expected 0000beef", mem2wb_o.wbData); end
    checks++; if (mem2wb_o.instValid !== 1'b1) begin errors++; $display("[TB] FAIL lhu_valid1: got %0h expected 1", mem2wb_o.instValid); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL lhu_req1: got %0h expected 0", dmem_req); end
    stall_i = 1'b0;
    @(negedge clk); #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL lhu_noreissue: got %0h expected 0", dmem_req); end
    checks++; if (mem2wb_o.instValid !== 1'b0) begin errors++; $display("[TB] FAIL lhu_after_valid: got %0h expected 0", mem2wb_o.instValid); end
  endtask

  task automatic test_reset_in_req();
    @(negedge clk);
    ex2mem_i = mk_pkt(OP_LOAD, 3'b010, 32'h0000_6000, 32'h0, 5'd8);
    @(negedge clk);
    ex2mem_i = '0;
    @(negedge clk); #1;
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL rstreq_req: got %0h expected 1", dmem_req); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL rstreq_drop: got %0h expected 0", dmem_req); end
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL rstreq_req_after: got %0h expected 0", dmem_req); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL rstreq_stall: got %0h expected 0", stall_o); end
    checks++; if (mem2wb_o.instValid !== 1'b0) begin errors++; $display("[TB] FAIL rstreq_valid: got %0h expected 0", mem2wb_o.instValid); end
    checks++; if (mem2wb_o.destReg !== 5'd0) begin errors++; $display("[TB] FAIL rstreq_dest: got %0d expected 0", mem2wb_o.destReg); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    ex2mem_i = mk_pkt(OP_ALU, 3'b000, 32'h0000_00AA, 32'h0, 5'd1);
    @(negedge clk);
    ex2mem_i = mk_pkt(OP_ALU, 3'b000, 32'h0000_00BB, 32'h0, 5'd2);
    #1;
    checks++; if (mem2wb_o.wbData !== 32'h0000_00AA) begin errors++; $display("[TB] FAIL b2b_first: got %h expected 000000aa", mem2wb_o.wbData); end
    @(negedge clk);
    ex2mem_i = '0;
    #1;
    checks++; if (mem2wb_o.wbData !== 32'h0000_00BB) begin errors++; $display("[TB] FAIL b2b_second: got %h expected 000000bb", mem2wb_o.wbData); end
    checks++; if (mem2wb_o.destReg !== 5'd2) begin errors++; $display("[TB] FAIL b2b_dest: got %0d expected 2", mem2wb_o.destReg); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lb();
    test_sh();
    test_sb();
    test_misaligned();
    test_lhu_stall();
    test_reset_in_req();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the port ex2mem_i, input, ex2memPkt, with fields pc, inst32, instValid, aux, destReg, res and storeData[31:0]; storeData is the rs2 value, newly added to ex2memPkt for this block.
REQ-004 The block SHALL have the port stall_i, input, 1 bit: downstream stall; freezes this stage.
REQ-005 The block SHALL have the port stall_o, output, 1 bit: upstream stall request while a memory access is pending.
REQ-006 The block SHALL have the port mem2wb_o, output, mem2wbPkt, with fields pc, inst32, instValid, destReg, wbData[31:0] and misaligned.
REQ-007 The block SHALL have the port dmem_req, output, 1 bit: data-bus request.
REQ-008 The block SHALL have the port dmem_we, output, 1 bit: 1 for a store, 0 for a load.
REQ-009 The block SHALL have the port dmem_addr, output, 32 bits: word-aligned address, res[31:2],2'b00.
REQ-010 The block SHALL have the port dmem_be, output, 4 bits: byte enables.
REQ-011 The block SHALL have the port dmem_wdata, output, 32 bits: store data, replicated per lane.
REQ-012 The block SHALL have the port dmem_ack, input, 1 bit: access complete; for a load, dmem_rdata is valid in this cycle.
REQ-013 The block SHALL have the port dmem_rdata, input, 32 bits: load data.

Function
REQ-014 The block SHALL hold an input pipeline register mem_reg, loaded from ex2mem_i on a clock edge when stall_o=0 and stall_i=0, and held otherwise.
REQ-015 Operation decode SHALL use mem_reg.inst32: opcode 0000011 is a load and 0100011 is a store, with funct3 selecting B/H/W/BU/HU; any other opcode, or instValid=0, is a non-memory operation.
REQ-016 A non-memory operation SHALL pass through with 0 added cycles: mem2wb_o.wbData=res, destReg and instValid copied, misaligned=0.
REQ-017 The FSM SHALL have the states IDLE, REQ and DONE.
REQ-018 IDLE SHALL move to REQ when mem_reg holds a valid, aligned memory operation; a non-memory or misaligned operation leaves the FSM in IDLE.
REQ-019 While in REQ, dmem_req SHALL be 1 and held stable, with dmem_we, dmem_addr, dmem_be and dmem_wdata constant.
REQ-020 REQ SHALL move to DONE on dmem_ack=1; a load also latches dmem_rdata into rdata_q.
REQ-021 DONE SHALL move to IDLE when stall_i=0 and SHALL hold while stall_i=1; the request is never reissued.
REQ-022 stall_o SHALL be 1 in IDLE when a memory operation is pending, and in REQ; it SHALL be 0 in DONE and for non-memory operations.
REQ-023 mem2wb_o.instValid SHALL be 0 and destReg 0 while a memory operation is in IDLE or REQ (a bubble); the real values appear only in DONE.
REQ-024 A memory operation SHALL therefore take at least 2 cycles, with IDLE->REQ on the 1st edge and REQ->DONE on the edge where ack=1.
REQ-025 Store byte enables SHALL be: SB gives be=1<<addr[1:0] with wdata={4{sd[7:0]}}; SH gives be=addr[1]?4'b1100:4'b0011 with wdata={2{sd[15:0]}}; SW gives be=4'b1111.
REQ-026 Load data SHALL select the lane from rdata_q by addr[1:0]; LB and LH sign-extend, LBU and LHU zero-extend, and LW passes the word unchanged.
REQ-027 A store in DONE SHALL output destReg=0 and wbData=0.
REQ-028 Misalignment is a halfword access with addr[0]=1, or a word access with addr[1:0]!=0.
REQ-029 A misaligned access SHALL issue no bus request, and SHALL output instValid=1, misaligned=1, destReg=0 in 0 added cycles.
REQ-030 Undefined load or store funct3 values SHALL be treated as misaligned.
REQ-031 When dmem_req=0, dmem_ack SHALL be ignored.
REQ-032 stall_i=1 during REQ SHALL NOT drop dmem_req; the access completes and the FSM waits in DONE.

Reset
REQ-033 On rst=1 at a clock edge, the block SHALL set the FSM to IDLE, mem_reg to all-zero (instValid=0), and rdata_q to 0.
REQ-034 After reset, the outputs SHALL be dmem_req=0, stall_o=0, mem2wb_o.instValid=0 and mem2wb_o.destReg=0.
REQ-035 rst during REQ SHALL drop dmem_req on the next cycle and discard the access; an ack arriving afterwards is ignored.

Verification
REQ-036 Scenario: ADD, res=0x0000_1234, destReg=5 -> same-cycle mem2wb_o wbData=0x1234, destReg=5, stall_o=0.
REQ-037 Scenario: LB, res=0x1003, rdata=0x80AA_BBCC, ack on the 1st REQ cycle -> be=4'b1111 is ignored for a load, addr=0x1000, stall_o=1 for 2 cycles, wbData=0xFFFF_FF80.
REQ-038 Scenario: SH, res=0x2002, storeData=0x1234_5678, ack after 3 REQ cycles -> dmem_req=1 for 3 cycles, be=4'b1100, wdata=0x5678_5678, we=1, then destReg=0.
REQ-039 Scenario: LW, res=0x3001 -> no dmem_req, misaligned=1, destReg=0, stall_o=0.
REQ-040 Scenario: LHU, res=0x4002, rdata=0xBEEF_0000, stall_i=1 for 2 cycles at DONE -> wbData=0x0000_BEEF held stable, no second request.
REQ-041 Scenario: rst=1 in REQ, ack the next cycle -> dmem_req=0 the cycle after reset, ack ignored, outputs at reset values.
